// File: rtl/bip_pkg.sv
// bip_pkg: shared definitions for the accumulator-processor control unit.
//   - opcode encodings (Instr[15:11])
//   - sequencer state enum
//   - accumulator/ALU mux and operation encodings
//   - ctrl_t: the decoded control word produced by bip_decode
package bip_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  // Accumulator source select
  localparam logic [1:0] SELA_RAM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

  // ALU operand B select
  localparam logic SELB_RAM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  // ALU operation
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       alu_op;
    logic       wr_acc;
    logic       rd_ram;
    logic       wr_ram;
    logic       is_halt;
  } ctrl_t;

endpackage

// File: rtl/bip_decode.sv
// bip_decode: purely combinational opcode -> control word.
//   opcode : instruction opcode field
//   ctrl   : mux selects, ALU op, strobe requests and halt flag
// Unknown opcodes decode to an all-zero word, i.e. a NOP.
module bip_decode
  import bip_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPC_W
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output ctrl_t                   ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_HLT: ctrl.is_halt = 1'b1;
      OP_STO: ctrl.wr_ram  = 1'b1;
      OP_LD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SELA_RAM;
      end
      OP_LDI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SELA_IMM;
      end
      OP_ADD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_RAM;
        ctrl.alu_op = ALU_ADD;
      end
      OP_ADDI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_IMM;
        ctrl.alu_op = ALU_ADD;
      end
      OP_SUB: begin
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_RAM;
        ctrl.alu_op = ALU_SUB;
      end
      OP_SUBI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_IMM;
        ctrl.alu_op = ALU_SUB;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/bip_sequencer.sv
// bip_sequencer: FETCH/DECODE/EXECUTE control unit for the 16-bit
// accumulator processor.
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : begin execution at pc 0 (honoured in IDLE/HALT only)
//   instr       : program-memory read data for the current pc
//   pc          : program-memory address
//   operand     : IR[10:0]; data-memory address / sign-extension input
//   sel_a       : accumulator source (0 ram, 1 sign-extended operand, 2 ALU)
//   sel_b       : ALU operand B (0 ram, 1 sign-extended operand)
//   alu_op      : 0 add, 1 subtract
//   wr_acc      : accumulator write strobe (EXECUTE)
//   rd_ram      : data-memory read enable (DECODE)
//   wr_ram      : data-memory write strobe (EXECUTE)
//   busy        : high in FETCH, DECODE, EXECUTE
//   halted      : high in HALT
//   cycle_cnt   : saturating count of busy cycles
//   dbg_state   : current FSM state
//
// Interface timing contract: pc is updated at the EXECUTE->FETCH edge and
// held through FETCH; instr must reflect pc before the FETCH->DECODE edge,
// where the instruction is captured. No handshake exists: every instruction
// takes exactly three cycles, and start is a level sampled only while idle
// or halted.
module bip_sequencer
  import bip_pkg::*;
#(
  parameter int PC_WIDTH     = 11,
  parameter int OPCODE_WIDTH = 5,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [OPCODE_WIDTH+PC_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]              pc,
  output logic [PC_WIDTH-1:0]              operand,
  output logic [1:0]                       sel_a,
  output logic                             sel_b,
  output logic                             alu_op,
  output logic                             wr_acc,
  output logic                             rd_ram,
  output logic                             wr_ram,
  output logic                             busy,
  output logic                             halted,
  output logic [CNT_WIDTH-1:0]             cycle_cnt,
  output state_e                           dbg_state
);

  state_e state;
  ctrl_t  dec;

  // EXECUTE-phase actions latched together with IR at the FETCH->DECODE
  // edge, so nothing in EXECUTE depends combinationally on instr.
  logic exe_wr_acc;
  logic exe_wr_ram;
  logic exe_halt;

  bip_decode #(
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_decode (
    .opcode(instr[OPCODE_WIDTH+PC_WIDTH-1 -: OPCODE_WIDTH]),
    .ctrl  (dec)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= '0;
      operand    <= '0;
      sel_a      <= SELA_RAM;
      sel_b      <= SELB_RAM;
      alu_op     <= ALU_ADD;
      wr_acc     <= 1'b0;
      rd_ram     <= 1'b0;
      wr_ram     <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      cycle_cnt  <= '0;
      exe_wr_acc <= 1'b0;
      exe_wr_ram <= 1'b0;
      exe_halt   <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses; only the state that owns them
      // raises them again below.
      wr_acc <= 1'b0;
      rd_ram <= 1'b0;
      wr_ram <= 1'b0;

      if (busy && (cycle_cnt != {CNT_WIDTH{1'b1}})) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end

      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state     <= ST_FETCH;
            pc        <= '0;
            cycle_cnt <= '0;
            busy      <= 1'b1;
            halted    <= 1'b0;
          end
        end

        ST_FETCH: begin
          // IR load: operand field and the decoded control word.
          state      <= ST_DECODE;
          operand    <= instr[PC_WIDTH-1:0];
          sel_a      <= dec.sel_a;
          sel_b      <= dec.sel_b;
          alu_op     <= dec.alu_op;
          rd_ram     <= dec.rd_ram;
          exe_wr_acc <= dec.wr_acc;
          exe_wr_ram <= dec.wr_ram;
          exe_halt   <= dec.is_halt;
        end

        ST_DECODE: begin
          state  <= ST_EXECUTE;
          wr_acc <= exe_wr_acc;
          wr_ram <= exe_wr_ram;
        end

        ST_EXECUTE: begin
          if (exe_halt) begin
            // pc keeps pointing at the HLT instruction.
            state  <= ST_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= ST_FETCH;
            pc    <= pc + 1'b1;  // wraps silently at the top of memory
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bip_sequencer.sv
// Directed testbench for bip_sequencer. Program memory is a simple array
// read combinationally at pc; expected values are hand-derived per program.
module tb_bip_sequencer;
  import bip_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [15:0] instr;
  logic [10:0] pc;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        alu_op;
  logic        wr_acc;
  logic        rd_ram;
  logic        wr_ram;
  logic        busy;
  logic        halted;
  logic [15:0] cycle_cnt;
  state_e      dbg_state;

  logic [15:0] prog [0:2047];
  assign instr = prog[pc];

  bip_sequencer #(
    .PC_WIDTH    (11),
    .OPCODE_WIDTH(5),
    .CNT_WIDTH   (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .instr    (instr),
    .pc       (pc),
    .operand  (operand),
    .sel_a    (sel_a),
    .sel_b    (sel_b),
    .alu_op   (alu_op),
    .wr_acc   (wr_acc),
    .rd_ram   (rd_ram),
    .wr_ram   (wr_ram),
    .busy     (busy),
    .halted   (halted),
    .cycle_cnt(cycle_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 2048; i++) prog[i] = 16'hF800;  // opcode 11111: NOP
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    if (!halted) check("halt_timeout", {31'd0, halted}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic any_strobe;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear_prog();

    // ---- reset state ----
    #12;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_pc", pc, 0);
    check("rst_operand", operand, 0);
    check("rst_sel", {sel_a, sel_b, alu_op}, 0);
    check("rst_strobes", {wr_acc, rd_ram, wr_ram}, 0);
    check("rst_busy_halted", {busy, halted}, 0);
    check("rst_cnt", cycle_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_no_start", dbg_state, ST_IDLE);

    // ---- LDI 5 ; HLT ----
    prog[0] = 16'h1805;
    prog[1] = 16'h0000;
    pulse_start();
    check("t1_c1_fetch", dbg_state, ST_FETCH);
    check("t1_c1_busy", busy, 1);
    tick();  // DECODE
    check("t1_c2_sel_a", sel_a, 1);
    check("t1_c2_operand", operand, 11'h005);
    check("t1_c2_rd_ram", rd_ram, 0);
    tick();  // EXECUTE
    check("t1_c3_strobes", {wr_acc, rd_ram, wr_ram}, 3'b100);
    check("t1_c3_sel_a", sel_a, 1);
    tick();  // FETCH of HLT
    check("t1_c4_pc", pc, 1);
    check("t1_c4_wr_acc", wr_acc, 0);
    tick();
    tick();  // EXECUTE of HLT
    check("t1_c6_strobes", {wr_acc, rd_ram, wr_ram}, 0);
    check("t1_c6_busy", busy, 1);
    tick();
    check("t1_halted", {busy, halted}, 2'b01);
    check("t1_state", dbg_state, ST_HALT);
    check("t1_pc", pc, 1);
    check("t1_cnt", cycle_cnt, 6);

    // ---- LD 0x010 ; ADD 0x011 ; STO 0x012 ; HLT ----
    clear_prog();
    prog[0] = 16'h1010;
    prog[1] = 16'h2011;
    prog[2] = 16'h0812;
    prog[3] = 16'h0000;
    // expected {wr_acc, rd_ram, wr_ram} per cycle, FETCH of LD first
    exp_q = '{16'd0, 16'd2, 16'd4, 16'd0, 16'd2, 16'd4,
              16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0};
    pulse_start();  // restart from HALT
    check("t2_restart_pc", pc, 0);
    check("t2_restart_cnt", cycle_cnt, 0);
    for (int c = 0; c < 12; c++) begin
      check($sformatf("t2_strb_c%0d", c), {wr_acc, rd_ram, wr_ram}, exp_q.pop_front());
      if (c == 1) check("t2_ld_sel_a", sel_a, 0);
      if (c == 4) check("t2_add_sel", {sel_a, sel_b, alu_op}, 4'b1000);
      if (c == 7 || c == 8) check($sformatf("t2_sto_operand_c%0d", c), operand, 11'h012);
      tick();
    end
    check("t2_halted", halted, 1);
    check("t2_pc", pc, 3);
    check("t2_cnt", cycle_cnt, 12);

    // ---- SUBI 0x7FF ; HLT ----
    clear_prog();
    prog[0] = 16'h3FFF;
    prog[1] = 16'h0000;
    pulse_start();
    tick();  // DECODE
    check("t3_sel", {sel_a, sel_b, alu_op}, 4'b1011);
    check("t3_operand", operand, 11'h7FF);
    check("t3_rd_ram", rd_ram, 0);
    tick();  // EXECUTE
    check("t3_strobes", {wr_acc, rd_ram, wr_ram}, 3'b100);
    tick();  // FETCH of HLT
    check("t3_wr_acc_one_cycle", wr_acc, 0);
    check("t3_pc", pc, 1);
    wait_halt(10);

    // ---- NOP sweep through all of memory, pc wrap ----
    clear_prog();
    exp_q.delete();
    for (int i = 0; i <= 2048; i++) exp_q.push_back(16'(i & 16'h07FF));
    any_strobe = 1'b0;
    pulse_start();
    for (int i = 0; i <= 2048; i++) begin
      check("t4_pc", pc, exp_q.pop_front());
      if (i == 2048) prog[1] = 16'h0000;  // end the run once wrap is seen
      tick();
      any_strobe |= wr_acc | rd_ram | wr_ram;
      tick();
      any_strobe |= wr_acc | rd_ram | wr_ram;
      tick();
    end
    check("t4_no_strobes", any_strobe, 0);
    check("t4_pc_after_wrap", pc, 1);
    wait_halt(10);
    check("t4_cnt", cycle_cnt, 6150);

    // ---- reset during EXECUTE of STO ----
    clear_prog();
    prog[0] = 16'h0812;
    prog[1] = 16'h0000;
    pulse_start();
    tick();
    tick();  // EXECUTE of STO
    check("t5_wr_ram_before", wr_ram, 1);
    rst_n = 1'b0;
    #1;
    check("t5_wr_ram_async", wr_ram, 0);
    check("t5_state_async", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t5_idle_after", dbg_state, ST_IDLE);
    check("t5_pc_after", pc, 0);
    pulse_start();
    check("t5_restart_fetch", dbg_state, ST_FETCH);
    check("t5_restart_pc", pc, 0);

    // ---- start while busy is ignored ----
    tick();  // DECODE
    start = 1'b1;
    tick();  // EXECUTE
    start = 1'b0;
    check("t6_busy_start_state", dbg_state, ST_EXECUTE);
    check("t6_wr_ram", wr_ram, 1);
    tick();
    check("t6_pc_not_reset", pc, 1);
    wait_halt(10);
    check("t6_halt_pc", pc, 1);

    // ---- start held high in HALT ----
    start = 1'b1;
    tick();
    check("t6_halt_restart_state", dbg_state, ST_FETCH);
    check("t6_halt_restart_pc", pc, 0);
    check("t6_halt_restart_cnt", cycle_cnt, 0);
    check("t6_halt_restart_halted", halted, 0);
    wait_halt(10);
    check("t6_rehalt_cnt", cycle_cnt, 6);
    tick();
    check("t6_rerun_fetch", dbg_state, ST_FETCH);
    start = 1'b0;
    wait_halt(10);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
